uart_receiver: RTL
==================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 18, SHALL set clk cycles per serial bit (synthesis value 5220); must be even and >= 4.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 clr  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 rcv  input  1  SHALL be the serial line from the sender; idle high; asynchronous to clk.
REQ-005 ack  input  1  SHALL be the consumer acknowledge of the 4-phase handshake.
REQ-006 data  output  8  SHALL hold the last delivered byte.
REQ-007 req  output  1  SHALL flag that data is valid and awaiting acknowledge.
REQ-008 ferr  output  1  SHALL be a sticky framing-error flag.
REQ-009 ovr  output  1  SHALL be a sticky overrun flag.

Function
REQ-010 rcv SHALL pass through a 2-flop synchronizer whose flops reset to 1; all logic uses the synchronized value (rs).
REQ-011 Frame SHALL be: start bit (0), 8 data bits in order data[1],data[2],...,data[7],data[0], then 2 stop bits (1).
REQ-012 Receive FSM states SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE: bit timer and bit index held at 0; rs==0 -> START, timer starts at 0 on the next clock.
REQ-014 START: at timer == CLKS_PER_BIT/2-1, rs==0 -> DATA and timer restarts at 0; rs==1 -> false start, return to IDLE with no flag change.
REQ-015 DATA: sample rs at each timer == CLKS_PER_BIT-1, then restart timer; samples 1..7 go to shift positions data[1]..data[7], sample 8 to data[0]; after sample 8 -> STOP.
REQ-016 STOP: sample rs at timer == CLKS_PER_BIT-1 (mid first stop bit), then return to IDLE; the second stop bit is not checked.
REQ-017 A stop sample of 0 SHALL set ferr and discard the byte; data and req are unchanged.
REQ-018 Stop sample 1 SHALL mark the frame complete on that clock.
REQ-019 Handshake FSM SHALL run independently of the receive FSM, with states HS_IDLE, HS_REQ, HS_WAIT.
REQ-020 Frame complete in HS_IDLE SHALL load data from the shift register and set req=1 on the next clock (latency 1 clk after the stop sample), moving to HS_REQ.
REQ-021 HS_REQ: req held at 1 and data held stable; ack==1 -> req=0, move to HS_WAIT.
REQ-022 HS_WAIT: ack==0 -> HS_IDLE.
REQ-023 Frame complete in HS_REQ or HS_WAIT SHALL drop the new byte, set ovr, and leave data and req untouched.
REQ-024 ack high while in HS_IDLE SHALL be ignored.
REQ-025 ferr and ovr SHALL clear only on reset.
REQ-026 rs toggling mid-bit SHALL have no effect; only the scheduled samples are used.

Reset
REQ-027 clr=0 SHALL immediately force data=8'h00, req=0, ferr=0, ovr=0, both FSMs to IDLE/HS_IDLE, timer and index to 0, and synchronizer flops to 1.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; after release, reception waits for the next falling edge of rs.
REQ-029 Reset release SHALL be synchronous to clk, and the design SHALL behave correctly if rcv is low at release, which is treated as a start.

Verification
REQ-030 CLKS_PER_BIT=18: send 0xA5 (serial 0,0,1,0,0,1,0,1,1,1,1); expect req=1 with data=8'hA5, and hold until ack.
REQ-031 After REQ-030, drive ack=1 then ack=0; expect req to fall 1 clk after ack rises, then send 0x3C and expect data=8'h3C.
REQ-032 Send a 4-clk low glitch on rcv; expect no req and no ferr, with the FSM back in IDLE.
REQ-033 Send 0x5A with the first stop bit driven 0; expect ferr=1, req=0, and data unchanged.
REQ-034 Send 0x11 without acking, then send 0x22; expect ovr=1, data=8'h11, and req still 1.
REQ-035 Assert clr during data bit 4 of a frame; expect all outputs at reset values; then send 0xFF and expect data=8'hFF.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits (data[1..7] then data[0]), 2 stop bits, mid-bit sampling,
// with a 4-phase req/ack handshake on the output byte and sticky framing/overrun flags.
module uart_receiver #(
   parameter int CLKS_PER_BIT = 18
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       rcv,
   input  logic       ack,
   output logic [7:0] data,
   output logic       req,
   output logic       ferr,
   output logic       ovr
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rxState_t;
   typedef enum logic [1:0] {HS_IDLE, HS_REQ, HS_WAIT} hsState_t;

   logic [1:0]    r_rstSync;
   logic          w_rstN;
   logic          r_sync1;
   logic          r_sync2;
   logic          w_rs;
   rxState_t      r_rxState;
   rxState_t      w_rxNext;
   logic [TW-1:0] r_timer;
   logic [TW-1:0] w_timerNext;
   logic [2:0]    r_idx;
   logic [2:0]    w_idxNext;
   logic [2:0]    w_bitPos;
   logic          w_sampleEn;
   logic          w_frameDone;
   logic          w_frameErr;
   logic [7:0]    r_shift;
   hsState_t      r_hsState;
   hsState_t      w_hsNext;
   logic          w_load;
   logic          w_ovrSet;
   logic [7:0]    r_data;
   logic          r_ferr;
   logic          r_ovr;

   // clr asserts everything at once but releases on a clock edge, two flops later
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) r_rstSync <= 2'b00;
      else      r_rstSync <= {r_rstSync[0], 1'b1};
   end

   assign w_rstN = r_rstSync[1];

   always_ff @(posedge clk or negedge w_rstN) begin
      if (!w_rstN) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rcv;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rs = r_sync2;

   always_ff @(posedge clk or negedge w_rstN) begin
      if (!w_rstN) begin
         r_rxState <= IDLE;
         r_timer   <= '0;
         r_idx     <= '0;
      end else begin
         r_rxState <= w_rxNext;
         r_timer   <= w_timerNext;
         r_idx     <= w_idxNext;
      end
   end

   always_comb begin
      w_rxNext    = r_rxState;
      w_timerNext = r_timer + 1'b1;
      w_idxNext   = r_idx;
      w_sampleEn  = 1'b0;
      w_frameDone = 1'b0;
      w_frameErr  = 1'b0;
      case (r_rxState)
         IDLE: begin
            w_timerNext = '0;
            w_idxNext   = '0;
            if (!w_rs) w_rxNext = START;
         end
         START: begin
            if (r_timer == HALF_LAST) begin
               w_timerNext = '0;
               w_rxNext    = w_rs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (r_timer == FULL_LAST) begin
               w_timerNext = '0;
               w_sampleEn  = 1'b1;
               w_idxNext   = r_idx + 1'b1;
               if (r_idx == 3'd7) w_rxNext = STOP;
            end
         end
         STOP: begin
            if (r_timer == FULL_LAST) begin
               w_timerNext = '0;
               w_frameDone = w_rs;
               w_frameErr  = !w_rs;
               w_rxNext    = IDLE;
            end
         end
         default: w_rxNext = IDLE;
      endcase
   end

   // The eighth sample on the wire is bit 0, so positions rotate by one
   assign w_bitPos = (r_idx == 3'd7) ? 3'd0 : r_idx + 3'd1;

   always_ff @(posedge clk or negedge w_rstN) begin
      if (!w_rstN)         r_shift <= '0;
      else if (w_sampleEn) r_shift[w_bitPos] <= w_rs;
   end

   always_ff @(posedge clk or negedge w_rstN) begin
      if (!w_rstN) r_hsState <= HS_IDLE;
      else         r_hsState <= w_hsNext;
   end

   always_comb begin
      w_hsNext = r_hsState;
      w_load   = 1'b0;
      w_ovrSet = 1'b0;
      case (r_hsState)
         HS_IDLE: begin
            if (w_frameDone) begin
               w_load   = 1'b1;
               w_hsNext = HS_REQ;
            end
         end
         HS_REQ: begin
            w_ovrSet = w_frameDone;
            if (ack) w_hsNext = HS_WAIT;
         end
         HS_WAIT: begin
            w_ovrSet = w_frameDone;
            if (!ack) w_hsNext = HS_IDLE;
         end
         default: w_hsNext = HS_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge w_rstN) begin
      if (!w_rstN) begin
         r_data <= 8'h00;
         r_ferr <= 1'b0;
         r_ovr  <= 1'b0;
      end else begin
         if (w_load)     r_data <= r_shift;
         if (w_frameErr) r_ferr <= 1'b1;
         if (w_ovrSet)   r_ovr  <= 1'b1;
      end
   end

   assign data = r_data;
   assign req  = (r_hsState == HS_REQ);
   assign ferr = r_ferr;
   assign ovr  = r_ovr;

endmodule
